pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the single-cycle 64-bit flag adder in the execute datapath.
- Splits the carry chain into SEG-bit segments, one segment per register stage.
- Adds subtract mode and RV64 word mode (ADDW/SUBW: low half, result sign-extended).
- Uses valid/ready handshakes on both sides, carries a tag for the issuing unit, and supports a flush. Intended for high-frequency builds where the 64-bit CLA path limits timing.

Parameters:
- WIDTH, 64, operand/result width; must be even.
- SEG, 16, bits resolved per stage; must divide WIDTH/2. NSTAGE = WIDTH/SEG.
- TAG_W, 5, width of the pass-through tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op1  in  WIDTH  operand A.
- in_op2  in  WIDTH  operand B.
- in_sub  in  1  1 = A - B, 0 = A + B.
- in_word  in  1  1 = operate on low WIDTH/2 bits, sign-extend result.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_result  out  WIDTH  sum/difference.
- out_overflow  out  1  signed overflow.
- out_sign  out  1  MSB of effective result.
- out_carry  out  1  carry-out XOR in_sub (add: carry, sub: borrow).
- out_zero  out  1  effective result == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
Reset and flush
- When rst_n = 0 at a clk edge, all stage valid bits clear. out_valid = 0 and in_ready = 1 from the next cycle.
- out_result, flags and out_tag reset to 0.
- flush = 1 at an edge clears all valid bits. A request presented in the same cycle is discarded even if in_valid & in_ready.
- Reset has priority over flush.

Pipeline control
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. No bubble collapsing.
- Latency: NSTAGE cycles from accept to out_valid when there is no stall. Throughput is 1 per cycle.
- While adv = 0, every stage holds and out_* stay stable.
- Accepting a new request in the same cycle the output is consumed is legal.

Arithmetic
- B' = in_sub ? ~in_op2 : in_op2. Carry-in c0 = in_sub.
- Stage k (0..NSTAGE-1) adds bits [k*SEG +: SEG] of A and B' with carry c_k, and registers the partial sum and c_{k+1}.
- Unconsumed operand bits, sub/word flags and tag travel alongside in the stage registers.
- Full mode (in_word = 0):
  - out_result = full sum.
  - overflow = c_WIDTH XOR c_(WIDTH-1).
  - sign = bit WIDTH-1.
  - carry = c_WIDTH XOR in_sub.
  - zero = ~|result.
- Word mode (in_word = 1), H = WIDTH/2:
  - The upper operand bits are ignored.
  - out_result = {{H{s[H-1]}}, s[H-1:0]}.
  - overflow = c_H XOR c_(H-1).
  - sign = s[H-1].
  - carry = c_H XOR in_sub.
  - zero = ~|s[H-1:0].
  - Word-mode results still use NSTAGE latency, so ordering is preserved.
- The flags register is computed in the final stage; no combinational path from in_* to out_*.
- Results leave in acceptance order.

Decomposition:
- Shared defines: REG_BUS width macro (existing), default SEG and TAG_W.
- Flag bundle field ordering (overflow, sign, carry, zero) matches the existing adder so the ALU mux is unchanged.
- One natural sub-module: adder_seg, a SEG-bit combinational adder returning sum, carry-out and carry into its MSB. It is instantiated once per stage via generate.
- Stage registers and handshake control stay in pipe_adder.

Test Plan:
All cases use WIDTH=64, SEG=16, latency 4; results checked against a reference model.
1. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1, tag 3 -> 4 cycles later: result 0, zero=1, carry=1, overflow=0, sign=0, tag 3.
2. Sub 0x8000_0000_0000_0000 - 0x1 -> result 0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=0, sign=0, zero=0.
3. Sub 0x0 - 0x1 -> result 0xFFFF_FFFF_FFFF_FFFF, carry=1 (borrow), sign=1, overflow=0.
4. Word add, op1 = 0xDEAD_BEEF_7FFF_FFFF, op2 = 0x1234_5678_0000_0001 -> result 0xFFFF_FFFF_8000_0000, overflow=1, sign=1, carry=0, zero=0.
5. Stream of 8 back-to-back adds (tags 0..7), out_ready = 0 for 3 cycles mid-stream:
   - in_ready = 0 exactly while out_valid & ~out_ready.
   - All 8 results arrive in tag order with none lost or duplicated.
   - Outputs stay stable while stalled.
6. Mid-flight kill:
   - flush with 3 ops in flight -> out_valid = 0 the next cycle, and none of those tags ever appear.
   - rst_n = 0 for one cycle mid-stream -> same, with out_result = 0.
   - A request accepted in the cycle after either kill returns correctly after 4 cycles.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared widths and the flag bundle for the pipelined execute adder.
package pipe_adder_pkg;

  localparam int unsigned REG_BUS   = 64;
  localparam int unsigned DEF_SEG   = 16;
  localparam int unsigned DEF_TAG_W = 5;

  // Field order matches the single-cycle adder so the ALU flag mux is unchanged.
  typedef struct packed {
    logic overflow;
    logic sign;
    logic carry;
    logic zero;
  } add_flags_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// One SEG-bit slice of the carry chain: sum, carry-out and carry into the MSB.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] sum_c,
  output logic           co_c,
  output logic           cm_c
);

  logic [SEG:0] full;

  // Plain add; the carry into the MSB falls out of a ^ b ^ s at that bit.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + (SEG+1)'(ci);
    sum_c = full[SEG-1:0];
    co_c  = full[SEG];
    cm_c  = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub with word mode: one SEG-bit carry segment per register stage.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = REG_BUS,
  parameter int unsigned SEG   = DEF_SEG,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_sub,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_sign,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned NSTAGE = WIDTH / SEG;
  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned WSEG   = HALF / SEG - 1;  // segment that produces c_H
  localparam int unsigned MID    = NSTAGE - 1;      // stages before the output stage

  logic adv;

  // Per-stage inputs: stage 0 sees the request, stage k sees stage k-1 registers.
  logic [WIDTH-1:0] src_a    [NSTAGE];
  logic [WIDTH-1:0] src_b    [NSTAGE];
  logic [WIDTH-1:0] src_s    [NSTAGE];
  logic             src_ci   [NSTAGE];
  logic             src_vld  [NSTAGE];
  logic             src_sub  [NSTAGE];
  logic             src_word [NSTAGE];
  logic             src_wov  [NSTAGE];
  logic             src_wcy  [NSTAGE];
  logic [TAG_W-1:0] src_tag  [NSTAGE];

  logic [SEG-1:0]   seg_s    [NSTAGE];
  logic             seg_co   [NSTAGE];
  logic             seg_cm   [NSTAGE];

  // Intermediate stage registers.
  logic             vld_q  [MID], vld_d  [MID];
  logic [WIDTH-1:0] a_q    [MID], a_d    [MID];
  logic [WIDTH-1:0] b_q    [MID], b_d    [MID];
  logic [WIDTH-1:0] s_q    [MID], s_d    [MID];
  logic             c_q    [MID], c_d    [MID];
  logic             sub_q  [MID], sub_d  [MID];
  logic             word_q [MID], word_d [MID];
  logic             wov_q  [MID], wov_d  [MID];
  logic             wcy_q  [MID], wcy_d  [MID];
  logic [TAG_W-1:0] tag_q  [MID], tag_d  [MID];

  // Output stage registers.
  logic             ovld_q, ovld_d;
  logic [WIDTH-1:0] res_q,  res_d;
  add_flags_t       flg_q,  flg_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [WIDTH-1:0] fin_sum;

  assign adv          = ~ovld_q | out_ready;
  assign in_ready     = adv;
  assign out_valid    = ovld_q;
  assign out_result   = res_q;
  assign out_overflow = flg_q.overflow;
  assign out_sign     = flg_q.sign;
  assign out_carry    = flg_q.carry;
  assign out_zero     = flg_q.zero;
  assign out_tag      = otag_q;

  // Route request / previous-stage registers into each stage's adder.
  always_comb begin
    src_a[0]    = in_op1;
    src_b[0]    = in_sub ? ~in_op2 : in_op2;
    src_s[0]    = '0;
    src_ci[0]   = in_sub;
    src_vld[0]  = in_valid;
    src_sub[0]  = in_sub;
    src_word[0] = in_word;
    src_wov[0]  = 1'b0;
    src_wcy[0]  = 1'b0;
    src_tag[0]  = in_tag;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      src_a[k]    = a_q[k-1];
      src_b[k]    = b_q[k-1];
      src_s[k]    = s_q[k-1];
      src_ci[k]   = c_q[k-1];
      src_vld[k]  = vld_q[k-1];
      src_sub[k]  = sub_q[k-1];
      src_word[k] = word_q[k-1];
      src_wov[k]  = wov_q[k-1];
      src_wcy[k]  = wcy_q[k-1];
      src_tag[k]  = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_seg
    adder_seg #(.SEG(SEG)) u_seg (
      .a     (src_a[k][k*SEG +: SEG]),
      .b     (src_b[k][k*SEG +: SEG]),
      .ci    (src_ci[k]),
      .sum_c (seg_s[k]),
      .co_c  (seg_co[k]),
      .cm_c  (seg_cm[k])
    );
  end

  // Next state: hold on stall, shift on advance, flush drops every valid bit.
  always_comb begin
    fin_sum = '0;
    for (int unsigned k = 0; k < MID; k++) begin
      vld_d[k]  = vld_q[k];
      a_d[k]    = a_q[k];
      b_d[k]    = b_q[k];
      s_d[k]    = s_q[k];
      c_d[k]    = c_q[k];
      sub_d[k]  = sub_q[k];
      word_d[k] = word_q[k];
      wov_d[k]  = wov_q[k];
      wcy_d[k]  = wcy_q[k];
      tag_d[k]  = tag_q[k];
    end
    ovld_d = ovld_q;
    res_d  = res_q;
    flg_d  = flg_q;
    otag_d = otag_q;

    if (adv) begin
      for (int unsigned k = 0; k < MID; k++) begin
        vld_d[k]             = src_vld[k];
        a_d[k]               = src_a[k];
        b_d[k]               = src_b[k];
        s_d[k]               = src_s[k];
        s_d[k][k*SEG +: SEG] = seg_s[k];
        c_d[k]               = seg_co[k];
        sub_d[k]             = src_sub[k];
        word_d[k]            = src_word[k];
        tag_d[k]             = src_tag[k];
        // Word-mode flags are captured where the low half's carry chain ends.
        wov_d[k] = (k == WSEG) ? (seg_co[k] ^ seg_cm[k]) : src_wov[k];
        wcy_d[k] = (k == WSEG) ? (seg_co[k] ^ src_sub[k]) : src_wcy[k];
      end

      fin_sum                  = src_s[MID];
      fin_sum[MID*SEG +: SEG]  = seg_s[MID];
      ovld_d                   = src_vld[MID];
      otag_d                   = src_tag[MID];
      if (src_word[MID]) begin
        res_d          = {{HALF{fin_sum[HALF-1]}}, fin_sum[HALF-1:0]};
        flg_d.overflow = src_wov[MID];
        flg_d.carry    = src_wcy[MID];
      end else begin
        res_d          = fin_sum;
        flg_d.overflow = seg_co[MID] ^ seg_cm[MID];
        flg_d.carry    = seg_co[MID] ^ src_sub[MID];
      end
      flg_d.sign = res_d[WIDTH-1];
      flg_d.zero = ~|res_d;
    end

    if (flush) begin
      for (int unsigned k = 0; k < MID; k++) vld_d[k] = 1'b0;
      ovld_d = 1'b0;
    end
  end

  // Stage registers; reset clears valids and the visible output bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < MID; k++) begin
        vld_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        c_q[k]    <= 1'b0;
        sub_q[k]  <= 1'b0;
        word_q[k] <= 1'b0;
        wov_q[k]  <= 1'b0;
        wcy_q[k]  <= 1'b0;
        tag_q[k]  <= '0;
      end
      ovld_q <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
      otag_q <= '0;
    end else begin
      for (int unsigned k = 0; k < MID; k++) begin
        vld_q[k]  <= vld_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        s_q[k]    <= s_d[k];
        c_q[k]    <= c_d[k];
        sub_q[k]  <= sub_d[k];
        word_q[k] <= word_d[k];
        wov_q[k]  <= wov_d[k];
        wcy_q[k]  <= wcy_d[k];
        tag_q[k]  <= tag_d[k];
      end
      ovld_q <= ovld_d;
      res_q  <= res_d;
      flg_q  <= flg_d;
      otag_q <= otag_d;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Randomized and directed checks of pipe_adder against an arithmetic reference model.
module tb_pipe_adder;

  localparam int unsigned W  = 64;
  localparam int unsigned TW = 5;

  typedef logic [72:0] exp_t;  // {tag, ov, sign, carry, zero, result}

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, in_sub, in_word;
  logic [W-1:0]  in_op1, in_op2, out_result;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready, out_overflow, out_sign, out_carry, out_zero;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  bit   obs_en = 1'b0;

  always #5 clk = ~clk;

  pipe_adder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_sub       (in_sub),
    .in_word      (in_word),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_sign     (out_sign),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_tag      (out_tag)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Exact signed/unsigned arithmetic; flags follow from the true result's range.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic word, input logic [4:0] tag);
    logic signed [65:0] sa, sb, ex;
    logic [64:0] usum;
    logic [63:0] r;
    logic ov, cy;
    if (word) begin
      sa = $signed({{34{a[31]}}, a[31:0]});
      sb = $signed({{34{b[31]}}, b[31:0]});
    end else begin
      sa = $signed({{2{a[63]}}, a});
      sb = $signed({{2{b[63]}}, b});
    end
    ex = sub ? sa - sb : sa + sb;
    if (word) begin
      r    = {{32{ex[31]}}, ex[31:0]};
      ov   = (ex != $signed({{34{ex[31]}}, ex[31:0]}));
      usum = 65'({1'b0, a[31:0]}) + 65'({1'b0, b[31:0]});
      cy   = sub ? (a[31:0] < b[31:0]) : usum[32];
    end else begin
      r    = ex[63:0];
      ov   = (ex != $signed({{2{ex[63]}}, ex[63:0]}));
      usum = {1'b0, a} + {1'b0, b};
      cy   = sub ? (a < b) : usum[64];
    end
    return {tag, ov, r[63], cy, (r == 64'h0), r};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      1: return 64'h0;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      5: return 64'h0000_0000_7FFF_FFFF;
      6: return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Compare the output against the scoreboard head and record accepted requests.
  task automatic observe();
    exp_t got;
    if (!obs_en) return;
    got = {out_tag, out_overflow, out_sign, out_carry, out_zero, out_result};
    check("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious", 128'(1), 128'(0));
      else begin
        check("result", 128'(got), 128'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready && rst_n && !flush) begin
      exp_q.push_back(model(in_op1, in_op2, in_sub, in_word, in_tag));
      n_acc++;
    end
    if (!rst_n || flush) exp_q.delete();
  endtask

  // Inputs are set just after a falling edge; observe mid-cycle, advance one cycle.
  task automatic tick();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic word, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    in_sub   = sub;
    in_word  = word;
    in_tag   = tag;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Called right after the accepting cycle; counts cycles until out_valid.
  task automatic wait_out(input string name);
    int cnt = 1;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check(name, 128'(cnt), 128'(4));
  endtask

  task automatic drain(input string name);
    int c = 0;
    idle();
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 40) begin
      tick();
      c++;
    end
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic word, input logic [4:0] tag,
                          input logic [3:0] flags, input logic [63:0] res);
    exp_t want;
    want = {tag, flags, res};
    out_ready = 1'b1;
    drive(a, b, sub, word, tag);
    tick();
    idle();
    wait_out({name, "_lat"});
    check(name, 128'({out_tag, out_overflow, out_sign, out_carry, out_zero, out_result}),
          128'(want));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cyc;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_sub = 1'b0; in_word = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    obs_en = 1'b1;

    // Reset state
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_ready", 128'(in_ready), 128'(1));
    check("rst_result", 128'(out_result), 128'(0));
    check("rst_flags", 128'({out_overflow, out_sign, out_carry, out_zero}), 128'(0));
    check("rst_tag", 128'(out_tag), 128'(0));

    // Directed arithmetic cases; flags are {ov, sign, carry, zero}
    directed("t1_add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 5'd3,
             4'b0011, 64'h0);
    directed("t2_sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 5'd4,
             4'b1000, 64'h7FFF_FFFF_FFFF_FFFF);
    directed("t3_sub_borrow", 64'h0, 64'h1, 1'b1, 1'b0, 5'd5,
             4'b0110, 64'hFFFF_FFFF_FFFF_FFFF);
    directed("t4_word_ovf", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0001, 1'b0, 1'b1, 5'd6,
             4'b1100, 64'hFFFF_FFFF_8000_0000);

    // Back-to-back stream with a three-cycle consumer stall
    n0 = n_acc; cyc = 0;
    while (n_acc - n0 < 8 && cyc < 50) begin
      drive(rnd64(), rnd64(), 1'b0, 1'b0, 5'(n_acc - n0));
      out_ready = !(cyc >= 5 && cyc < 8);
      tick();
      cyc++;
    end
    check("stream_count", 128'(n_acc - n0), 128'(8));
    drain("stream_drain");

    // Flush with three operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'b0, 5'(20 + i));
      tick();
    end
    drive(rnd64(), rnd64(), 1'b0, 1'b0, 5'd23);
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    check("flush_valid", 128'(out_valid), 128'(0));
    drive(64'h1234, 64'h4321, 1'b0, 1'b0, 5'd9);
    tick();
    idle();
    wait_out("flush_lat");
    drain("flush_drain");

    // Reset pulse with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive(rnd64(), rnd64(), 1'b0, 1'($urandom_range(0, 1)), 5'(24 + i));
      tick();
    end
    rst_n = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    check("rstm_valid", 128'(out_valid), 128'(0));
    check("rstm_result", 128'(out_result), 128'(0));
    check("rstm_ready", 128'(in_ready), 128'(1));
    drive(64'hFFFF_FFFF_0000_0005, 64'h7, 1'b1, 1'b1, 5'd10);
    tick();
    idle();
    wait_out("rstm_lat");
    drain("rstm_drain");

    // Random traffic with random backpressure and occasional flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                                          1'($urandom_range(0, 1)), 5'($urandom));
      else idle();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      if (flush) out_ready = 1'b0;
      tick();
    end
    flush = 1'b0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
